vend_arbiter: RTL and testbench

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter.sv | 155 +++++++++++++++
 tb/tb_vend_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// ---------------------------------------------------------------------------
// vend_arbiter
//   Coin-accepting vending controller with two coin slots. Each slot uses a
//   valid/ready handshake. When both slots offer a coin on the same cycle they
//   are served round-robin. Accepted coins add to a credit accumulator. Once
//   the credit reaches PRICE, the controller enters DISPENSE. It then drops one
//   item per cycle, and each drop removes PRICE from the credit, until the
//   remaining credit is below PRICE.
//
// Parameters
//   PRICE       item price in credit units, 1..7
//
// Ports
//   clock       system clock, rising-edge active
//   reset       synchronous, active-high reset
//   coin_a      slot A coin code (00=0, 01=1, 10=3, 11=5 units)
//   valid_a     slot A offers a coin (held until accepted)
//   ready_a     slot A coin accepted this cycle when valid_a & ready_a
//   coin_b      slot B coin code
//   valid_b     slot B offers a coin
//   ready_b     slot B coin accepted this cycle when valid_b & ready_b
//   drop        one-cycle dispense strobe per item (Moore, high in DISPENSE)
//   credit      accumulated credit, unsigned
//   last_grant  slot of the most recently accepted coin (0=A, 1=B)
//   sales       dispensed item count, wraps modulo 256
// ---------------------------------------------------------------------------
module vend_arbiter #(
  parameter int PRICE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin_a,
  input  logic       valid_a,
  output logic       ready_a,
  input  logic [1:0] coin_b,
  input  logic       valid_b,
  output logic       ready_b,
  output logic       drop,
  output logic [3:0] credit,
  output logic       last_grant,
  output logic [7:0] sales
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] DISPENSE = 1'b1;

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  // Credit never exceeds PRICE-1+5 = 11. A 4-bit sum therefore cannot wrap,
  // and no saturation is needed.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      2'b00:   v = 4'd0;
      2'b01:   v = 4'd1;
      2'b10:   v = 4'd3;
      default: v = 4'd5;
    endcase
    return v;
  endfunction

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] credit_nxt;
  logic [7:0] sales_nxt;
  logic       last_grant_nxt;

  logic       idle;
  logic       grant_a;
  logic       grant_b;
  logic       accept;
  logic [1:0] coin_sel;
  logic [3:0] credit_sum;
  logic [3:0] credit_rem;

  assign idle = (state == IDLE);

  // Round-robin arbitration. A lone requester always wins. On a tie, the
  // slot that did not win last time is served. last_grant resets to B, so
  // slot A takes the first tie after reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (idle) begin
      if (valid_a && valid_b) begin
        grant_a = last_grant;
        grant_b = ~last_grant;
      end else begin
        grant_a = valid_a;
        grant_b = valid_b;
      end
    end
  end

  assign ready_a = grant_a;
  assign ready_b = grant_b;
  assign accept  = grant_a | grant_b;

  assign coin_sel   = grant_b ? coin_b : coin_a;
  assign credit_sum = credit + coin_value(coin_sel);
  assign credit_rem = credit - PRICE_U;

  // drop is decoded from state only, so it is a pure Moore output.
  assign drop = (state == DISPENSE);

  always_comb begin
    state_nxt      = state;
    credit_nxt     = credit;
    sales_nxt      = sales;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        // A zero-value coin still completes the handshake and moves
        // last_grant.
        if (accept) begin
          credit_nxt     = credit_sum;
          last_grant_nxt = grant_b;
          if (credit_sum >= PRICE_U) begin
            state_nxt = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        // Every dispense cycle pays for exactly one item. Stay in DISPENSE
        // while the remainder still covers another item, so successive drops
        // come out back to back.
        credit_nxt = credit_rem;
        sales_nxt  = sales + 8'd1;
        if (credit_rem < PRICE_U) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset overrides any handshake or dispense that would happen on the same
  // edge. A dispense in progress is abandoned and its credit is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= 4'd0;
      sales      <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      sales      <= sales_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
module tb_vend_arbiter;

  localparam int PRICE = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin_a = 2'b00;
  logic       valid_a = 1'b0;
  logic       ready_a;
  logic [1:0] coin_b = 2'b00;
  logic       valid_b = 1'b0;
  logic       ready_b;
  logic       drop;
  logic [3:0] credit;
  logic       last_grant;
  logic [7:0] sales;

  vend_arbiter #(.PRICE(PRICE)) dut (
    .clock      (clock),
    .reset      (reset),
    .coin_a     (coin_a),
    .valid_a    (valid_a),
    .ready_a    (ready_a),
    .coin_b     (coin_b),
    .valid_b    (valid_b),
    .ready_b    (ready_b),
    .drop       (drop),
    .credit     (credit),
    .last_grant (last_grant),
    .sales      (sales)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the machine is summarised as an amount of money, a sales
  // tally and the last winner. Any credit of PRICE or more means an item is
  // owed, so the vending side is busy and refuses coins until it is paid out.
  int m_credit;
  int m_sales;
  bit m_last;
  int coin_units[4] = '{0, 1, 3, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the DUT
  // against the model, then advance the model at the rising edge.
  task automatic step(input bit r, input bit va, input logic [1:0] ca,
                      input bit vb, input logic [1:0] cb,
                      output bit acc_a, output bit acc_b);
    bit busy, ea, eb;
    @(negedge clock);
    reset = r; valid_a = va; coin_a = ca; valid_b = vb; coin_b = cb;
    #1;
    busy = (m_credit >= PRICE);
    ea = !busy && va && (!vb || m_last);
    eb = !busy && vb && (!va || !m_last);
    chk("ready_a", ready_a, ea);
    chk("ready_b", ready_b, eb);
    chk("one_ready", ready_a & ready_b, 0);
    chk("drop", drop, busy);
    chk("credit", credit, m_credit);
    chk("sales", sales, m_sales);
    chk("last_grant", last_grant, m_last);
    @(posedge clock);
    acc_a = ea && !r;
    acc_b = eb && !r;
    if (r) begin
      m_credit = 0; m_sales = 0; m_last = 1'b1;
    end else if (busy) begin
      m_credit -= PRICE;
      m_sales = (m_sales + 1) % 256;
    end else if (ea) begin
      m_credit += coin_units[ca]; m_last = 1'b0;
    end else if (eb) begin
      m_credit += coin_units[cb]; m_last = 1'b1;
    end
  endtask

  task automatic go(input bit r, input bit va, input logic [1:0] ca,
                    input bit vb, input logic [1:0] cb);
    bit xa, xb;
    step(r, va, ca, vb, cb, xa, xb);
  endtask

  initial begin
    bit acc_a, acc_b;
    bit pa, pb;
    logic [1:0] pca, pcb;
    int guard;

    // Initial reset with no checks, because the DUT state is unknown until
    // the first reset edge.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    m_credit = 0; m_sales = 0; m_last = 1'b1;
    #1;
    chk("reset_credit", credit, 0);
    chk("reset_sales", sales, 0);
    chk("reset_last", last_grant, 1);
    chk("reset_drop", drop, 0);

    // Slot A only, coin 01 four times, then the dispense cycle.
    repeat (4) go(0, 1, 2'b01, 0, 2'b00);
    go(0, 0, 2'b00, 0, 2'b00);
    go(0, 0, 2'b00, 0, 2'b00);
    chk("sales_after_one", sales, 1);

    // Both slots valid with coin 01 every cycle from reset: grants A,B,A,B.
    go(1, 0, 2'b00, 0, 2'b00);
    repeat (6) go(0, 1, 2'b01, 1, 2'b01);
    go(0, 0, 2'b00, 0, 2'b00);

    // Credit 3, then A inserts a 5: two back-to-back drops.
    go(1, 0, 2'b00, 0, 2'b00);
    repeat (3) go(0, 1, 2'b01, 0, 2'b00);
    go(0, 1, 2'b11, 0, 2'b00);
    #1;
    chk("credit_8", credit, 8);
    go(0, 0, 2'b00, 0, 2'b00);
    go(0, 0, 2'b00, 0, 2'b00);
    go(0, 0, 2'b00, 0, 2'b00);

    // B holds coin 10 throughout a dispense and is taken in the first idle cycle.
    go(1, 0, 2'b00, 0, 2'b00);
    repeat (3) go(0, 1, 2'b01, 0, 2'b00);
    go(0, 1, 2'b11, 0, 2'b00);
    acc_b = 1'b0;
    for (int i = 0; i < 8 && !acc_b; i++) step(0, 0, 2'b00, 1, 2'b10, acc_a, acc_b);
    chk("held_b_accepted", acc_b, 1);
    #1;
    chk("held_b_credit", credit, 3);
    go(0, 0, 2'b00, 0, 2'b00);

    // Reset during a dispense with credit 8 aborts it.
    go(1, 0, 2'b00, 0, 2'b00);
    repeat (3) go(0, 1, 2'b01, 0, 2'b00);
    go(0, 1, 2'b11, 0, 2'b00);
    go(1, 0, 2'b00, 0, 2'b00);
    go(0, 0, 2'b00, 0, 2'b00);

    // Zero-value coins still hand over and flip last_grant.
    repeat (3) go(0, 1, 2'b00, 1, 2'b00);

    // Randomized traffic. A valid coin is held until it is accepted.
    pa = 0; pb = 0; pca = 0; pcb = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin pa = 1; pca = 2'($urandom_range(0, 3)); end
      if (!pb && ($urandom_range(0, 2) != 0)) begin pb = 1; pcb = 2'($urandom_range(0, 3)); end
      if ($urandom_range(0, 63) == 0) begin
        step(1, 0, 2'b00, 0, 2'b00, acc_a, acc_b);
        pa = 0; pb = 0;
      end else begin
        step(0, pa, pca, pb, pcb, acc_a, acc_b);
        if (acc_a) pa = 0;
        if (acc_b) pb = 0;
      end
    end

    // Run sales up to 255, then through the wrap to 0.
    go(1, 0, 2'b00, 0, 2'b00);
    guard = 0;
    while (m_sales != 255 && guard < 3000) begin
      go(0, 1, 2'b11, 0, 2'b00);
      guard++;
    end
    #1;
    chk("sales_255", sales, 255);
    guard = 0;
    while (m_sales != 0 && guard < 20) begin
      go(0, 1, 2'b11, 0, 2'b00);
      guard++;
    end
    #1;
    chk("sales_wrap", sales, 0);
    repeat (4) go(0, 0, 2'b00, 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
